payload_engine_ctrl: RTL and testbench
======================================

PAYLOAD_ENGINE_CTRL -- requirements
Module: payload_engine_ctrl

Interface
REQ-001 Parameter N_ENG, default 32: number of engine match lines collected.
REQ-002 Parameter MAX_LEN, default 1500: maximum payload bytes forwarded to the engines per packet.
REQ-003 Parameter LEN_W, default 16: width of the length counter and of r_len.
REQ-004 Parameter PIPE_LAT, default 2: cycles from the last eng_en pulse until eng_match is stable.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  in  1  clock; all logic on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 s_valid  in  1  input payload beat valid.
REQ-009 s_ready  out  1  input beat accepted when s_valid&s_ready.
REQ-010 s_data  in  8  payload byte.
REQ-011 s_sop  in  1  first byte of packet.
REQ-012 s_eop  in  1  last byte of packet.
REQ-013 eng_sod  out  1  engine bank clear; drives every engine's sod.
REQ-014 eng_en  out  1  engine bank step enable; one pulse per forwarded byte.
REQ-015 eng_byte  out  8  byte to the character-class decoder, aligned with eng_en.
REQ-016 eng_match  in  N_ENG  sticky engine outputs.
REQ-017 r_valid  out  1  result valid.
REQ-018 r_ready  in  1  result consumed when r_valid&r_ready.
REQ-019 r_match  out  N_ENG  sampled match vector.
REQ-020 r_len  out  LEN_W  bytes accepted for the packet, saturating at all-ones.
REQ-021 r_trunc  out  1  packet exceeded MAX_LEN.
REQ-022 drop_cnt  out  16  count of beats discarded outside a packet, wrapping.

Function
REQ-023 FSM states: IDLE, CLEAR, RUN, DRAIN, REPORT; all outputs are registered.
REQ-024 IDLE: s_ready=1 unless s_valid&s_sop; an accepted non-sop beat is discarded and drop_cnt increments.
REQ-025 IDLE with s_valid&s_sop: hold s_ready=0 and go to CLEAR, leaving the sop beat pending.
REQ-026 CLEAR lasts 1 cycle: eng_sod=1, length counter=0, trunc flag=0; then go to RUN.
REQ-027 RUN: s_ready=1; each accepted beat increments the length counter, saturating at 2^LEN_W-1.
REQ-028 RUN: each accepted beat with length counter < MAX_LEN produces eng_en=1 and eng_byte=s_data on the next cycle (latency 1).
REQ-029 RUN: an accepted beat with length counter >= MAX_LEN is consumed with eng_en=0 and sets the trunc flag.
REQ-030 RUN: s_sop on an accepted beat is treated as ordinary data.
REQ-031 RUN: an accepted beat with s_eop causes a transition to DRAIN; a beat with both s_sop and s_eop is a 1-byte packet.
REQ-032 DRAIN: s_ready=0 and eng_en=0 for PIPE_LAT+1 cycles; then sample eng_match into r_match and go to REPORT.
REQ-033 REPORT: r_valid=1; r_match, r_len and r_trunc are held stable while r_valid=1; s_ready=0.
REQ-034 REPORT with r_valid&r_ready: r_valid=0 on the next cycle and return to IDLE; a back-to-back sop goes to CLEAR from IDLE the following cycle.
REQ-035 eng_sod=0 and eng_en is never asserted in any state other than CLEAR and RUN respectively; eng_sod and eng_en are never asserted together.

Reset
REQ-036 While rst=1: state=IDLE, eng_sod=1, eng_en=0, eng_byte=0, s_ready=0, r_valid=0, r_match=0, r_len=0, r_trunc=0, drop_cnt=0.
REQ-037 First cycle after rst falls: eng_sod=0 and s_ready follows REQ-024.
REQ-038 rst asserted in any state aborts the packet without a result; no r_valid is produced for it.

Verification
REQ-039 5-byte packet "Delta", eng_match forced to 0x1 during DRAIN -> one eng_sod pulse, 5 eng_en pulses carrying 0x44 0x65 0x6C 0x74 0x61, then r_valid with r_match=0x1, r_len=5, r_trunc=0.
REQ-040 MAX_LEN=4 with a 6-byte packet -> 4 eng_en pulses, all 6 beats accepted, r_len=6, r_trunc=1.
REQ-041 3 beats without sop, then a sop/eop single beat -> drop_cnt=3, 1 eng_en pulse, r_len=1.
REQ-042 r_ready held at 0 for 10 cycles in REPORT while the next sop is waiting -> r_* stable, s_ready=0 throughout; after the handshake, CLEAR for the next packet.
REQ-043 rst pulsed mid-RUN after 2 bytes -> no r_valid, eng_sod=1 during reset; the next packet reports only its own length.
REQ-044 Random s_valid gaps with r_ready always 1 -> per packet, count of eng_en equals min(len, MAX_LEN) and count of eng_sod equals 1.

Source files
------------

// File: rtl/payload_engine_ctrl.sv
// -----------------------------------------------------------------------------
// payload_engine_ctrl
//
// Purpose:
//   Sequences one packet at a time through a bank of match engines. A start of
//   packet clears the bank (eng_sod), payload bytes are forwarded one per cycle
//   (eng_en/eng_byte) up to MAX_LEN bytes, and the bank is given PIPE_LAT+1
//   quiet cycles to settle. The sticky match lines are then sampled and
//   reported together with the packet length and a truncation flag. Beats that
//   arrive outside a packet are discarded and counted.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   s_valid/s_ready payload input handshake, s_data byte, s_sop/s_eop framing
//   eng_sod         engine bank clear
//   eng_en/eng_byte engine step enable and byte, one pulse per forwarded byte
//   eng_match       sticky match lines from the engines
//   r_valid/r_ready result handshake; r_match, r_len, r_trunc result fields
//   drop_cnt        wrapping count of beats discarded outside a packet
//
// Handshakes:
//   A beat or result transfers on a rising edge where valid and ready are both
//   high. valid, once raised, is held with stable payload until it transfers;
//   ready may change freely and never depends on the payload contents except
//   for the start-of-packet stall described below.
// -----------------------------------------------------------------------------
module payload_engine_ctrl #(
    parameter int N_ENG    = 32,
    parameter int MAX_LEN  = 1500,
    parameter int LEN_W    = 16,
    parameter int PIPE_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [7:0]       s_data,
    input  logic             s_sop,
    input  logic             s_eop,
    output logic             eng_sod,
    output logic             eng_en,
    output logic [7:0]       eng_byte,
    input  logic [N_ENG-1:0] eng_match,
    output logic             r_valid,
    input  logic             r_ready,
    output logic [N_ENG-1:0] r_match,
    output logic [LEN_W-1:0] r_len,
    output logic             r_trunc,
    output logic [15:0]      drop_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        REPORT = 3'd4
    } state_t;

    state_t           state;
    logic             rdy_q;
    logic [LEN_W-1:0] len_q;
    logic             trunc_q;
    logic [7:0]       drain_cnt;
    logic             idle_sop;
    logic             accept;
    logic             below_max;

    // The ready flag itself is registered. The only combinational term is the
    // start-of-packet stall in IDLE: a sop beat must stay pending (not be
    // swallowed) while the engine bank is cleared, and that decision has to be
    // made in the same cycle the sop is presented.
    assign idle_sop  = (state == IDLE) && s_valid && s_sop;
    assign s_ready   = rdy_q && !idle_sop;
    assign accept    = s_valid && s_ready;
    assign below_max = (32'(len_q) < 32'(MAX_LEN));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rdy_q     <= 1'b0;
            eng_sod   <= 1'b1;
            eng_en    <= 1'b0;
            eng_byte  <= 8'd0;
            r_valid   <= 1'b0;
            r_match   <= '0;
            r_len     <= '0;
            r_trunc   <= 1'b0;
            drop_cnt  <= 16'd0;
            len_q     <= '0;
            trunc_q   <= 1'b0;
            drain_cnt <= 8'd0;
        end else begin
            // Single-cycle strobes.
            eng_en  <= 1'b0;
            eng_sod <= 1'b0;

            case (state)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (idle_sop) begin
                        // Leave the sop beat pending; it is taken in RUN.
                        rdy_q   <= 1'b0;
                        eng_sod <= 1'b1;
                        state   <= CLEAR;
                    end else if (accept) begin
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end

                CLEAR: begin
                    len_q   <= '0;
                    trunc_q <= 1'b0;
                    rdy_q   <= 1'b1;
                    state   <= RUN;
                end

                RUN: begin
                    if (!rdy_q) begin
                        // Tail cycle after the eop beat: its eng_en pulse is on
                        // the output now, so the quiet drain window starts next.
                        drain_cnt <= 8'd0;
                        state     <= DRAIN;
                    end else if (accept) begin
                        if (len_q != {LEN_W{1'b1}}) begin
                            len_q <= len_q + LEN_W'(1);
                        end
                        if (below_max) begin
                            eng_en   <= 1'b1;
                            eng_byte <= s_data;
                        end else begin
                            trunc_q <= 1'b1;
                        end
                        if (s_eop) begin
                            rdy_q <= 1'b0;
                        end
                    end
                end

                DRAIN: begin
                    // PIPE_LAT+1 cycles with no engine activity, then sample.
                    if (drain_cnt == 8'(PIPE_LAT)) begin
                        r_match <= eng_match;
                        r_len   <= len_q;
                        r_trunc <= trunc_q;
                        r_valid <= 1'b1;
                        state   <= REPORT;
                    end else begin
                        drain_cnt <= drain_cnt + 8'd1;
                    end
                end

                REPORT: begin
                    if (r_ready) begin
                        r_valid <= 1'b0;
                        rdy_q   <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: begin
                    rdy_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_payload_engine_ctrl.sv
// -----------------------------------------------------------------------------
// tb_payload_engine_ctrl
//
// Two instances share one stimulus stream: dut_a with the default MAX_LEN and
// dut_b with MAX_LEN=4, so every packet also exercises truncation on dut_b.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge as well.
// -----------------------------------------------------------------------------
module tb_payload_engine_ctrl;

    localparam int N_ENG = 32;
    localparam int LEN_W = 16;
    localparam int MAX_B = 4;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- signals
    logic             s_valid = 1'b0;
    logic [7:0]       s_data  = 8'd0;
    logic             s_sop   = 1'b0;
    logic             s_eop   = 1'b0;
    logic             r_ready = 1'b1;
    logic [N_ENG-1:0] eng_match = '0;

    logic             a_s_ready, a_eng_sod, a_eng_en, a_r_valid, a_r_trunc;
    logic [7:0]       a_eng_byte;
    logic [N_ENG-1:0] a_r_match;
    logic [LEN_W-1:0] a_r_len;
    logic [15:0]      a_drop_cnt;

    logic             b_s_ready, b_eng_sod, b_eng_en, b_r_valid, b_r_trunc;
    logic [7:0]       b_eng_byte;
    logic [N_ENG-1:0] b_r_match;
    logic [LEN_W-1:0] b_r_len;
    logic [15:0]      b_drop_cnt;

    payload_engine_ctrl #(.N_ENG(N_ENG), .LEN_W(LEN_W)) dut_a (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data),
        .s_sop(s_sop), .s_eop(s_eop),
        .eng_sod(a_eng_sod), .eng_en(a_eng_en), .eng_byte(a_eng_byte),
        .eng_match(eng_match),
        .r_valid(a_r_valid), .r_ready(r_ready), .r_match(a_r_match),
        .r_len(a_r_len), .r_trunc(a_r_trunc), .drop_cnt(a_drop_cnt)
    );

    payload_engine_ctrl #(.N_ENG(N_ENG), .MAX_LEN(MAX_B), .LEN_W(LEN_W)) dut_b (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data),
        .s_sop(s_sop), .s_eop(s_eop),
        .eng_sod(b_eng_sod), .eng_en(b_eng_en), .eng_byte(b_eng_byte),
        .eng_match(eng_match),
        .r_valid(b_r_valid), .r_ready(r_ready), .r_match(b_r_match),
        .r_len(b_r_len), .r_trunc(b_r_trunc), .drop_cnt(b_drop_cnt)
    );

    // ---------------------------------------------------------------- checking
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- scoreboard
    logic [7:0] exp_q[$];   // bytes dut_a must forward, in order
    logic [7:0] pkt_q[$];   // packet being driven
    int a_en = 0, b_en = 0, a_sod = 0, b_sod = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (a_eng_en) begin
                a_en++;
                if (exp_q.size() == 0) check("a_extra_en", 32'd1, 32'd0);
                else check("a_eng_byte", {24'd0, a_eng_byte}, {24'd0, exp_q.pop_front()});
            end
            if (b_eng_en) b_en++;
            if (a_eng_sod) a_sod++;
            if (b_eng_sod) b_sod++;
            if (a_eng_sod && a_eng_en) check("a_sod_with_en", 32'd1, 32'd0);
            if (b_eng_sod && b_eng_en) check("b_sod_with_en", 32'd1, 32'd0);
        end
    end

    task automatic clear_mon();
        a_en = 0; b_en = 0; a_sod = 0; b_sod = 0;
        exp_q.delete();
    endtask

    // ---------------------------------------------------------------- drivers
    // Presents one beat and returns on the falling edge after it transfers.
    task automatic send_beat(input logic [7:0] d, input logic sop, input logic eop);
        int budget;
        budget  = 50;
        s_valid = 1'b1; s_data = d; s_sop = sop; s_eop = eop;
        #1;
        while (!a_s_ready && budget > 0) begin
            @(negedge clk); #1;
            budget--;
        end
        if (budget == 0) check("beat_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
    endtask

    task automatic send_pkt(input int gap_max);
        for (int i = 0; i < pkt_q.size(); i++) exp_q.push_back(pkt_q[i]);
        for (int i = 0; i < pkt_q.size(); i++) begin
            send_beat(pkt_q[i], i == 0, i == pkt_q.size() - 1);
            if (i != pkt_q.size() - 1) repeat ($urandom_range(gap_max, 0)) @(negedge clk);
        end
    endtask

    // Waits for the result and checks every field on both instances.
    task automatic wait_report(input string tag, input int len, input logic [31:0] match);
        int budget;
        int exp_b;
        budget = 40;
        while (!a_r_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        exp_b = (len < MAX_B) ? len : MAX_B;
        check({tag, "_a_r_valid"}, {31'd0, a_r_valid}, 32'd1);
        check({tag, "_b_r_valid"}, {31'd0, b_r_valid}, 32'd1);
        check({tag, "_a_r_match"}, a_r_match, match);
        check({tag, "_b_r_match"}, b_r_match, match);
        check({tag, "_a_r_len"}, {16'd0, a_r_len}, len);
        check({tag, "_b_r_len"}, {16'd0, b_r_len}, len);
        check({tag, "_a_r_trunc"}, {31'd0, a_r_trunc}, 32'd0);
        check({tag, "_b_r_trunc"}, {31'd0, b_r_trunc}, (len > MAX_B) ? 32'd1 : 32'd0);
        check({tag, "_a_en_cnt"}, a_en, len);
        check({tag, "_b_en_cnt"}, b_en, exp_b);
        check({tag, "_a_sod_cnt"}, a_sod, 32'd1);
        check({tag, "_b_sod_cnt"}, b_sod, 32'd1);
        check({tag, "_bytes_left"}, exp_q.size(), 32'd0);
    endtask

    task automatic finish_report(input string tag);
        r_ready = 1'b1;
        @(negedge clk);
        check({tag, "_r_valid_drop"}, {31'd0, a_r_valid}, 32'd0);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_eng_sod", {31'd0, a_eng_sod}, 32'd1);
        check("rst_eng_en", {31'd0, a_eng_en}, 32'd0);
        check("rst_eng_byte", {24'd0, a_eng_byte}, 32'd0);
        check("rst_s_ready", {31'd0, a_s_ready}, 32'd0);
        check("rst_r_valid", {31'd0, a_r_valid}, 32'd0);
        check("rst_r_match", a_r_match, 32'd0);
        check("rst_r_len", {16'd0, a_r_len}, 32'd0);
        check("rst_r_trunc", {31'd0, a_r_trunc}, 32'd0);
        check("rst_drop_cnt", {16'd0, a_drop_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_eng_sod", {31'd0, a_eng_sod}, 32'd0);
        check("post_rst_s_ready", {31'd0, a_s_ready}, 32'd1);
        clear_mon();

        // "Delta": match lines rise while the bank drains
        pkt_q = '{8'h44, 8'h65, 8'h6C, 8'h74, 8'h61};
        send_pkt(0);
        eng_match = 32'h1;
        wait_report("delta", 5, 32'h1);
        finish_report("delta");
        clear_mon();

        // 6-byte packet: dut_b forwards 4, accepts all 6
        eng_match = 32'h0000_0F00;
        pkt_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        send_pkt(0);
        wait_report("six", 6, 32'h0000_0F00);
        finish_report("six");
        clear_mon();

        // 3 stray beats, then a one-byte packet
        for (int i = 0; i < 3; i++) send_beat(8'hD0 + 8'(i), 1'b0, 1'b0);
        check("drop_a", {16'd0, a_drop_cnt}, 32'd3);
        check("drop_b", {16'd0, b_drop_cnt}, 32'd3);
        check("drop_no_en", a_en, 32'd0);
        eng_match = 32'h8000_0001;
        pkt_q = '{8'h5A};
        send_pkt(0);
        wait_report("single", 1, 32'h8000_0001);
        finish_report("single");
        clear_mon();

        // Result held 10 cycles with the next sop waiting
        r_ready   = 1'b0;
        eng_match = 32'h0000_00A5;
        pkt_q = '{8'h41, 8'h42};
        send_pkt(0);
        wait_report("stall", 2, 32'h0000_00A5);
        eng_match = 32'hFFFF_FFFF;
        s_valid = 1'b1; s_data = 8'h78; s_sop = 1'b1; s_eop = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_r_valid", {31'd0, a_r_valid}, 32'd1);
            check("stall_r_len", {16'd0, a_r_len}, 32'd2);
            check("stall_r_match", a_r_match, 32'h0000_00A5);
            check("stall_s_ready", {31'd0, a_s_ready}, 32'd0);
        end
        finish_report("stall");
        clear_mon();
        check("stall_sop_pending", {31'd0, a_s_ready}, 32'd0);
        @(negedge clk);
        check("stall_clear_sod", {31'd0, a_eng_sod}, 32'd1);
        eng_match = 32'h0000_003C;
        pkt_q = '{8'h78, 8'h79};
        send_pkt(0);
        wait_report("after_stall", 2, 32'h0000_003C);
        finish_report("after_stall");
        clear_mon();

        // Reset mid-RUN after 2 bytes
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send_beat(8'h11, 1'b1, 1'b0);
        send_beat(8'h22, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_eng_sod", {31'd0, a_eng_sod}, 32'd1);
        check("mid_rst_eng_en", {31'd0, a_eng_en}, 32'd0);
        check("mid_rst_r_valid", {31'd0, a_r_valid}, 32'd0);
        check("mid_rst_s_ready", {31'd0, a_s_ready}, 32'd0);
        check("mid_rst_drop_cnt", {16'd0, a_drop_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_r_valid2", {31'd0, a_r_valid}, 32'd0);
        clear_mon();
        eng_match = 32'h0000_0002;
        pkt_q = '{8'h31, 8'h32, 8'h33};
        send_pkt(0);
        wait_report("post_abort", 3, 32'h0000_0002);
        finish_report("post_abort");
        clear_mon();

        // Random gaps between beats
        eng_match = '0;
        for (int p = 0; p < 3; p++) begin
            pkt_q.delete();
            for (int i = 0; i < 3 + 3 * p; i++) pkt_q.push_back(8'($urandom_range(255, 0)));
            send_pkt(3);
            wait_report("gaps", 3 + 3 * p, 32'h0);
            finish_report("gaps");
            clear_mon();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
